// File: rtl/carfield_apb_periph_bridge.sv
// carfield_apb_periph_bridge
//   Single-outstanding bridge from a 32-bit request/response port to the
//   Carfield APB peripheral cluster. It decodes the request address against
//   per-slave regions and runs one APB SETUP/ACCESS transfer on the selected
//   slave. It then returns read data and an error flag. A decode miss or an
//   ACCESS phase that exceeds TimeoutCycles returns ErrRdata with error set.
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   req_valid_i / req_ready_o         request handshake (ready only when idle)
//   req_addr_i, req_write_i           byte address, 1 = write
//   req_wdata_i, req_wstrb_i          write data and byte strobes
//   rsp_valid_o / rsp_ready_i         response handshake
//   rsp_rdata_o, rsp_error_o          read data (0 for writes), error flag
//   paddr_o, pwrite_o, pwdata_o,      registered APB address/controls
//   pstrb_o
//   psel_o, penable_o                 one-hot slave select, APB enable
//   pready_i, prdata_i, pslverr_i     per-slave APB returns (slave i at [32i+:32])

module carfield_apb_periph_bridge #(
   parameter int unsigned                 NumApbMst     = 5,
   parameter logic [NumApbMst-1:0][31:0]  ApbBase       = {32'h2000_9000, 32'h2000_1000,
                                                           32'h2000_7000, 32'h2000_5000,
                                                           32'h2000_4000},
   parameter logic [31:0]                 ApbSize       = 32'h0000_1000,
   parameter int unsigned                 TimeoutCycles = 256,
   parameter logic [31:0]                 ErrRdata      = 32'hBADC_AB1E
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [31:0]               req_addr_i,
   input  logic                      req_write_i,
   input  logic [31:0]               req_wdata_i,
   input  logic [3:0]                req_wstrb_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [31:0]               rsp_rdata_o,
   output logic                      rsp_error_o,
   output logic [31:0]               paddr_o,
   output logic                      pwrite_o,
   output logic [31:0]               pwdata_o,
   output logic [3:0]                pstrb_o,
   output logic [NumApbMst-1:0]      psel_o,
   output logic                      penable_o,
   input  logic [NumApbMst-1:0]      pready_i,
   input  logic [32*NumApbMst-1:0]   prdata_i,
   input  logic [NumApbMst-1:0]      pslverr_i
);

   localparam int unsigned IdxW = (NumApbMst > 1) ? $clog2(NumApbMst) : 1;
   localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess,
      StResp
   } stateT;

   stateT            state, stateNext;
   logic [31:0]      paddrQ, paddrNext;
   logic             pwriteQ, pwriteNext;
   logic [31:0]      pwdataQ, pwdataNext;
   logic [3:0]       pstrbQ, pstrbNext;
   logic [IdxW-1:0]  selQ, selNext;
   logic [CntW-1:0]  cntQ, cntNext, cntPlus;
   logic [31:0]      rdataQ, rdataNext;
   logic             errQ, errNext;

   logic             hit;
   logic [IdxW-1:0]  hitIdx;
   logic             selReady, selErr;
   logic [31:0]      selRdata;
   logic [NumApbMst-1:0] selOneHot;

   // Address decode. Walk from the highest index down so the lowest matching
   // index is the one left standing. The upper bound is computed in 33 bits
   // so a region ending at 4 GiB cannot wrap.
   always_comb begin
      hit    = 1'b0;
      hitIdx = '0;
      for (int unsigned i = NumApbMst; i > 0; i--) begin
         if ((req_addr_i >= ApbBase[i-1]) &&
             ({1'b0, req_addr_i} < ({1'b0, ApbBase[i-1]} + {1'b0, ApbSize}))) begin
            hit    = 1'b1;
            hitIdx = IdxW'(i - 1);
         end
      end
   end

   // Only the selected slave's return signals are observed.
   always_comb begin
      selReady  = 1'b0;
      selErr    = 1'b0;
      selRdata  = '0;
      selOneHot = '0;
      for (int unsigned i = 0; i < NumApbMst; i++) begin
         if (IdxW'(i) == selQ) begin
            selReady     = pready_i[i];
            selErr       = pslverr_i[i];
            selRdata     = prdata_i[32*i +: 32];
            selOneHot[i] = 1'b1;
         end
      end
   end

   assign cntPlus = cntQ + CntW'(1);

   always_comb begin
      stateNext  = state;
      paddrNext  = paddrQ;
      pwriteNext = pwriteQ;
      pwdataNext = pwdataQ;
      pstrbNext  = pstrbQ;
      selNext    = selQ;
      cntNext    = cntQ;
      rdataNext  = rdataQ;
      errNext    = errQ;

      unique case (state)
         StIdle: begin
            if (req_valid_i) begin
               paddrNext  = req_addr_i;
               pwriteNext = req_write_i;
               pwdataNext = req_wdata_i;
               pstrbNext  = req_wstrb_i;
               if (hit) begin
                  selNext   = hitIdx;
                  cntNext   = '0;
                  stateNext = StSetup;
               end else begin
                  rdataNext = ErrRdata;
                  errNext   = 1'b1;
                  stateNext = StResp;
               end
            end
         end
         StSetup: begin
            stateNext = StAccess;
         end
         StAccess: begin
            // A ready slave wins over a timeout landing in the same cycle.
            if (selReady) begin
               rdataNext = pwriteQ ? '0 : selRdata;
               errNext   = selErr;
               stateNext = StResp;
            end else if (cntPlus == CntW'(TimeoutCycles)) begin
               rdataNext = ErrRdata;
               errNext   = 1'b1;
               stateNext = StResp;
            end else begin
               cntNext = cntPlus;
            end
         end
         StResp: begin
            if (rsp_ready_i) begin
               stateNext = StIdle;
            end
         end
         default: stateNext = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= StIdle;
         paddrQ  <= '0;
         pwriteQ <= 1'b0;
         pwdataQ <= '0;
         pstrbQ  <= '0;
         selQ    <= '0;
         cntQ    <= '0;
         rdataQ  <= '0;
         errQ    <= 1'b0;
      end else begin
         state   <= stateNext;
         paddrQ  <= paddrNext;
         pwriteQ <= pwriteNext;
         pwdataQ <= pwdataNext;
         pstrbQ  <= pstrbNext;
         selQ    <= selNext;
         cntQ    <= cntNext;
         rdataQ  <= rdataNext;
         errQ    <= errNext;
      end
   end

   assign req_ready_o = (state == StIdle);
   assign rsp_valid_o = (state == StResp);
   assign rsp_rdata_o = rdataQ;
   assign rsp_error_o = errQ;
   assign paddr_o     = paddrQ;
   assign pwrite_o    = pwriteQ;
   assign pwdata_o    = pwdataQ;
   assign pstrb_o     = pstrbQ;
   assign psel_o      = ((state == StSetup) || (state == StAccess)) ? selOneHot : '0;
   assign penable_o   = (state == StAccess);

endmodule

// File: tb/tb_carfield_apb_periph_bridge.sv
module tb_carfield_apb_periph_bridge;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          req_valid_i;
   logic          req_ready_o;
   logic [31:0]   req_addr_i;
   logic          req_write_i;
   logic [31:0]   req_wdata_i;
   logic [3:0]    req_wstrb_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic [31:0]   rsp_rdata_o;
   logic          rsp_error_o;
   logic [31:0]   paddr_o;
   logic          pwrite_o;
   logic [31:0]   pwdata_o;
   logic [3:0]    pstrb_o;
   logic [4:0]    psel_o;
   logic          penable_o;
   logic [4:0]    pready_i;
   logic [159:0]  prdata_i;
   logic [4:0]    pslverr_i;

   carfield_apb_periph_bridge dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .req_write_i (req_write_i),
      .req_wdata_i (req_wdata_i),
      .req_wstrb_i (req_wstrb_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_error_o (rsp_error_o),
      .paddr_o     (paddr_o),
      .pwrite_o    (pwrite_o),
      .pwdata_o    (pwdata_o),
      .pstrb_o     (pstrb_o),
      .psel_o      (psel_o),
      .penable_o   (penable_o),
      .pready_i    (pready_i),
      .prdata_i    (prdata_i),
      .pslverr_i   (pslverr_i)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] BadData = 32'hBADC_AB1E;
   logic [31:0] regionBase [5];

   int errors = 0;
   int checks = 0;

   // Behaviour of the selected slave for the current transfer.
   int          curWaits = 0;
   logic        curErr   = 1'b0;
   logic [31:0] curData  = '0;
   int          accCnt   = 0;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          waits;    // ACCESS cycles before pready; >= 256 means never
      logic        slvErr;
      logic [31:0] slvData;
      int          hold;     // cycles rsp_ready_i is held low after rsp_valid
      logic [4:0]  expSel;
      logic        expErr;
      logic [31:0] expRdata;
      int          expLat;   // cycles from accept edge to rsp_valid
   } vecT;

   // Slave environment: the slave seen in ACCESS answers after curWaits cycles;
   // every other slave shows ready=1 and inverted data/error so that sampling
   // the wrong slave is visible.
   always @(negedge clk) begin
      for (int i = 0; i < 5; i++) begin
         if (psel_o[i] && penable_o) begin
            pready_i[i]          = (accCnt == curWaits);
            pslverr_i[i]         = (accCnt == curWaits) ? curErr : ~curErr;
            prdata_i[32*i +: 32] = curData;
         end else begin
            pready_i[i]          = 1'b1;
            pslverr_i[i]         = ~curErr;
            prdata_i[32*i +: 32] = ~curData;
         end
      end
      if (penable_o) accCnt++;
      else           accCnt = 0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vecT mk(logic [31:0] a, logic w, logic [31:0] wd, logic [3:0] ws,
                              int wt, logic se, logic [31:0] sd, int hold,
                              logic [4:0] es, logic ee, logic [31:0] er, int el);
      vecT v;
      v.addr = a; v.wr = w; v.wdata = wd; v.wstrb = ws; v.waits = wt; v.slvErr = se;
      v.slvData = sd; v.hold = hold; v.expSel = es; v.expErr = ee; v.expRdata = er;
      v.expLat = el;
      return v;
   endfunction

   // Reference model: region lookup with plain arithmetic, then the outcome
   // and latency from the slave's wait count.
   function automatic vecT refModel(vecT v);
      vecT r = v;
      int  idx = -1;
      for (int i = 4; i >= 0; i--) begin
         if (v.addr >= regionBase[i] && (v.addr - regionBase[i]) < 32'h1000) idx = i;
      end
      if (idx < 0) begin
         r.expSel = '0; r.expErr = 1'b1; r.expRdata = BadData; r.expLat = 1;
      end else begin
         r.expSel = 5'(1 << idx);
         if (v.waits >= 256) begin
            r.expErr = 1'b1; r.expRdata = BadData; r.expLat = 3 + 255;
         end else begin
            r.expErr = v.slvErr; r.expRdata = v.wr ? 32'h0 : v.slvData;
            r.expLat = 3 + v.waits;
         end
      end
      return r;
   endfunction

   task automatic runVec(input vecT v, input string tag);
      int          lat = -1;
      int          pselCnt = 0, badSel = 0, penCnt = 0, ctlBad = 0, rdyBad = 0, holdBad = 0;
      int          expPsel, expPen;
      logic [31:0] heldData;
      logic        heldErr;
      @(negedge clk);
      req_valid_i = 1'b1;
      req_addr_i  = v.addr;
      req_write_i = v.wr;
      req_wdata_i = v.wdata;
      req_wstrb_i = v.wstrb;
      curWaits    = v.waits;
      curErr      = v.slvErr;
      curData     = v.slvData;
      chk({tag, ".acceptReady"}, 32'(req_ready_o), 32'd1);
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      req_addr_i  = $urandom;
      req_write_i = ~v.wr;
      req_wdata_i = $urandom;
      req_wstrb_i = ~v.wstrb;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (psel_o != '0) begin
            if (psel_o === v.expSel) pselCnt++;
            else                     badSel++;
            if (paddr_o !== v.addr || pwrite_o !== v.wr || pwdata_o !== v.wdata ||
                pstrb_o !== v.wstrb) ctlBad++;
         end
         if (penable_o) penCnt++;
         if (req_ready_o) rdyBad++;
         if (rsp_valid_o) begin
            lat = c;
            break;
         end
      end
      expPsel = (v.expSel != '0) ? v.expLat - 1 : 0;
      expPen  = (v.expSel != '0) ? v.expLat - 2 : 0;
      chk({tag, ".latency"}, 32'(lat), 32'(v.expLat));
      chk({tag, ".rdata"}, rsp_rdata_o, v.expRdata);
      chk({tag, ".error"}, 32'(rsp_error_o), 32'(v.expErr));
      chk({tag, ".pselCycles"}, 32'(pselCnt), 32'(expPsel));
      chk({tag, ".penableCycles"}, 32'(penCnt), 32'(expPen));
      chk({tag, ".wrongPsel"}, 32'(badSel), 32'd0);
      chk({tag, ".apbCtrlUnstable"}, 32'(ctlBad), 32'd0);
      chk({tag, ".readyWhileBusy"}, 32'(rdyBad), 32'd0);
      heldData = rsp_rdata_o;
      heldErr  = rsp_error_o;
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         if (!rsp_valid_o || rsp_rdata_o !== heldData || rsp_error_o !== heldErr ||
             req_ready_o || psel_o != '0) holdBad++;
      end
      if (v.hold > 0) chk({tag, ".rspHold"}, 32'(holdBad), 32'd0);
      rsp_ready_i = 1'b1;
      @(negedge clk);
      rsp_ready_i = 1'b0;
      chk({tag, ".backToIdle"}, {30'd0, rsp_valid_o, req_ready_o}, 32'd1);
   endtask

   vecT tbl[$];

   initial begin
      int seenPen;
      int spurious;
      vecT v;
      regionBase[0] = 32'h2000_4000;
      regionBase[1] = 32'h2000_5000;
      regionBase[2] = 32'h2000_7000;
      regionBase[3] = 32'h2000_1000;
      regionBase[4] = 32'h2000_9000;

      rst_i = 1'b1; req_valid_i = 1'b0; rsp_ready_i = 1'b0;
      req_addr_i = '0; req_write_i = 1'b0; req_wdata_i = '0; req_wstrb_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.reqReady", 32'(req_ready_o), 32'd1);
      chk("reset.rspValid", 32'(rsp_valid_o), 32'd0);
      chk("reset.rspRdata", rsp_rdata_o, 32'd0);
      chk("reset.rspError", 32'(rsp_error_o), 32'd0);
      chk("reset.pselPenable", {26'd0, psel_o, penable_o}, 32'd0);
      chk("reset.apbCtrl", {27'd0, pstrb_o, pwrite_o} | paddr_o | pwdata_o, 32'd0);
      rst_i = 1'b0;

      //         addr          wr   wdata          wstrb    waits se  slvData        hold expSel    err  rdata          lat
      tbl.push_back(mk(32'h2000_4010, 0, 32'h0,         4'hF,    0,    0, 32'h1234_5678, 0,   5'b00001, 0, 32'h1234_5678, 3));
      tbl.push_back(mk(32'h2000_9FFC, 1, 32'hA5A5_A5A5, 4'b0011, 3,    0, 32'hDEAD_BEEF, 2,   5'b10000, 0, 32'h0,         6));
      tbl.push_back(mk(32'h2000_3000, 0, 32'h0,         4'hF,    0,    0, 32'h1111_1111, 0,   5'b00000, 1, BadData,       1));
      tbl.push_back(mk(32'h2000_1000, 0, 32'h0,         4'hF,    1,    1, 32'h0BAD_F00D, 0,   5'b01000, 1, 32'h0BAD_F00D, 4));
      tbl.push_back(mk(32'h2000_7000, 0, 32'h0,         4'hF,    1000, 0, 32'h2222_2222, 10,  5'b00100, 1, BadData,       258));
      tbl.push_back(mk(32'h2000_7FFC, 0, 32'h0,         4'hF,    255,  0, 32'h3333_3333, 0,   5'b00100, 0, 32'h3333_3333, 258));
      tbl.push_back(mk(32'h2000_7004, 0, 32'h0,         4'hF,    254,  0, 32'h3434_3434, 0,   5'b00100, 0, 32'h3434_3434, 257));
      tbl.push_back(mk(32'h2000_5000, 0, 32'h0,         4'hF,    0,    0, 32'h4444_4444, 0,   5'b00010, 0, 32'h4444_4444, 3));
      tbl.push_back(mk(32'h2000_4FFF, 0, 32'h0,         4'hF,    2,    0, 32'h5555_5555, 1,   5'b00001, 0, 32'h5555_5555, 5));
      tbl.push_back(mk(32'h2000_8000, 0, 32'h0,         4'hF,    0,    0, 32'h6666_6666, 0,   5'b00000, 1, BadData,       1));
      tbl.push_back(mk(32'h2000_0FFF, 0, 32'h0,         4'hF,    0,    0, 32'h6767_6767, 0,   5'b00000, 1, BadData,       1));
      tbl.push_back(mk(32'hFFFF_FFFF, 0, 32'h0,         4'hF,    0,    0, 32'h6868_6868, 0,   5'b00000, 1, BadData,       1));
      tbl.push_back(mk(32'h2000_5004, 1, 32'h0F0F_0F0F, 4'b1000, 2,    1, 32'h7777_7777, 0,   5'b00010, 1, 32'h0,         5));
      tbl.push_back(mk(32'h2000_A000, 1, 32'h1357_9BDF, 4'hF,    0,    0, 32'h8888_8888, 3,   5'b00000, 1, BadData,       1));

      foreach (tbl[i]) runVec(tbl[i], $sformatf("vec%0d", i));

      // Reset during ACCESS aborts the transfer with no response.
      @(negedge clk);
      req_valid_i = 1'b1; req_addr_i = 32'h2000_4020; req_write_i = 1'b0;
      curWaits = 1000; curErr = 1'b0; curData = 32'h9999_9999;
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      seenPen = 0;
      for (int c = 0; c < 6 && seenPen == 0; c++) begin
         @(negedge clk);
         if (penable_o) seenPen = 1;
      end
      chk("rstAbort.reachedAccess", 32'(seenPen), 32'd1);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      chk("rstAbort.apbDropped", {26'd0, psel_o, penable_o}, 32'd0);
      chk("rstAbort.handshake", {30'd0, rsp_valid_o, req_ready_o}, 32'd1);
      spurious = 0;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid_o || psel_o != '0) spurious++;
      end
      chk("rstAbort.noResponse", 32'(spurious), 32'd0);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 40; n++) begin
         v.wr    = 1'($urandom_range(0, 1));
         v.wdata = $urandom;
         v.wstrb = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) != 0)
            v.addr = regionBase[$urandom_range(0, 4)] + 32'($urandom_range(0, 32'hFFF));
         else
            v.addr = 32'h2000_0000 + 32'($urandom_range(0, 32'hFFFF));
         v.waits   = ($urandom_range(0, 15) == 0) ? 300 : int'($urandom_range(0, 6));
         v.slvErr  = ($urandom_range(0, 3) == 0);
         v.slvData = $urandom;
         v.hold    = int'($urandom_range(0, 3));
         v = refModel(v);
         runVec(v, $sformatf("rnd%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
